wasm_leb_encoder: RTL
=====================

// Module: wasm_leb_encoder
// PURPOSE
//  Streaming LEB128 encoder: accepts one DATA_W-bit integer per transaction and emits its
//  LEB128 byte sequence, one byte per out handshake, low group first. It is the emit-side
//  counterpart of the bootrom loader's LEB128 decoding. Used by image/section builders that
//  write WASM headers, counts, lengths and indices into ROM/mem byte streams.
// PARAMETERS
//  DATA_W     32  width of in_value; max encoded length NB = ceil(DATA_W/7) (5 at 32)
//  PAD_BYTES  0   0 = minimal encoding; N>0 = always emit exactly N bytes (N >= NB required)
// PORTS
//  clk         in   1       clock; all logic on posedge clk
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       in_value is valid
//  in_ready    out  1       encoder can accept a value (high only in IDLE)
//  in_value    in   DATA_W  integer to encode
//  in_signed   in   1       1 = SLEB128, 0 = ULEB128 (present only with WASM_SLEB_EN)
//  out_valid   out  1       out_byte holds a valid encoded byte
//  out_ready   in   1       consumer takes out_byte this cycle
//  out_byte    out  8       encoded byte; bit7 = continuation
//  out_last    out  1       out_byte is the final byte (bit7 == 0)
//  byte_idx    out  3       index of out_byte within the current encoding (0-based)
//  busy        out  1       high from acceptance until the last byte is taken
// BEHAVIOUR
//  - Reset values: in_ready=1 (IDLE), out_valid=0, out_byte=0, out_last=0, byte_idx=0, busy=0.
//  - FSM: IDLE -> EMIT on in_valid&&in_ready; EMIT -> IDLE on out_valid&&out_ready&&out_last.
//  - Accept: value latched into DATA_W remainder reg `rem`, sign latched, byte count reset.
//  - Latency: first byte has out_valid=1 the cycle after acceptance; one byte per cycle while
//    out_ready held high; in_ready returns the cycle after the last handshake (1 bubble).
//  - Byte formation: payload = rem[6:0]; on handshake rem <= rem >> 7 (logical for unsigned,
//    arithmetic for signed), byte_idx increments.
//  - Unsigned termination (minimal): byte is last when (rem >> 7) == 0.
//  - Signed termination (minimal): last when (rem >>> 7) is all-0 and payload[6]==0, or
//    all-1 and payload[6]==1.
//  - Padding (PAD_BYTES=N>0): bytes 0..N-2 carry bit7=1, byte N-1 is last; once value is
//    exhausted, filler payload is 7'h00 (unsigned/non-negative) or 7'h7F (negative).
//  - out_byte/out_last/byte_idx held stable while out_valid && !out_ready.
//  - in_valid while busy: ignored (in_ready=0); no value is queued.
//  - Value 0 emits single 0x00; DATA_W=32 all-ones unsigned emits FF FF FF FF 0F (5 bytes).
//  - byte_idx never exceeds max(NB, PAD_BYTES)-1; the NB-th byte is always last in minimal mode.
//  - rst mid-EMIT: remaining bytes dropped, all outputs to reset values next cycle.
//  - rst has priority over any simultaneous handshake.
// CONFIGURATION
//  WASM_SLEB_EN defined: in_signed port exists; signed termination, arithmetic shift and
//    0x7F padding fill are implemented.
//  WASM_SLEB_EN undefined: no in_signed port; encoder is ULEB128-only, logical shift,
//    0x00 fill; signed logic absent from the netlist.
// TESTING
//  1. rst held 2 cycles -> in_ready=1, out_valid=0, busy=0, byte_idx=0.
//  2. in_value=0x0, out_ready=1 -> one byte 0x00, out_last=1, in_ready high 1 cycle later.
//  3. in_value=624485, out_ready=1 -> E5 8E 26 on 3 consecutive cycles, last on 0x26.
//  4. in_value=0xFFFFFFFF, out_ready toggled 1/0 -> FF FF FF FF 0F, byte stable when stalled,
//     in_valid pulses during EMIT ignored.
//  5. WASM_SLEB_EN, in_signed=1: -1 -> 7F; -65 -> BF 7F; +64 -> C0 00; unsigned 64 -> 40.
//  6. PAD_BYTES=5: in_value=3 -> 83 80 80 80 00; rst asserted after byte 2 -> out_valid=0
//     next cycle, next accepted value encodes from byte_idx 0.

Source files
------------

// File: rtl/wasm_leb_encoder.sv
// Streaming LEB128 encoder: one integer in, one encoded byte per out handshake.
// Define WASM_SLEB_EN to add the in_signed port and SLEB128 support.
module wasm_leb_encoder #(
  parameter int DATA_W    = 32,
  parameter int PAD_BYTES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
`ifdef WASM_SLEB_EN
  input  logic              in_signed,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [2:0]        byte_idx,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] rem_shr;
  logic [2:0]        idx_q, idx_d;
  logic              last_min;
  logic              last;
  logic              shr_zero;
`ifdef WASM_SLEB_EN
  logic              sgn_q, sgn_d;
  logic              shr_ones;
`endif

  always_comb begin
`ifdef WASM_SLEB_EN
    rem_shr  = {{7{sgn_q & rem_q[DATA_W-1]}},
                rem_q[DATA_W-1:7]};
    shr_zero = (rem_shr == '0);
    shr_ones = &rem_shr;
    // Signed stop: remaining bits are pure sign extension of payload bit 6
    if (sgn_q)
      last_min = (shr_zero && !rem_q[6]) ||
                 (shr_ones && rem_q[6]);
    else
      last_min = shr_zero;
`else
    rem_shr  = {7'b0, rem_q[DATA_W-1:7]};
    shr_zero = (rem_shr == '0);
    last_min = shr_zero;
`endif
    if (PAD_BYTES > 0)
      last = (idx_q == 3'(PAD_BYTES - 1));
    else
      last = last_min;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
`ifdef WASM_SLEB_EN
    sgn_d   = sgn_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = in_value;
          idx_d   = 3'd0;
          state_d = EMIT;
`ifdef WASM_SLEB_EN
          sgn_d   = in_signed;
`endif
        end
      end
      EMIT: begin
        if (out_ready) begin
          rem_d = rem_shr;
          if (last) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= 3'd0;
`ifdef WASM_SLEB_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
`ifdef WASM_SLEB_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  // Padding fill falls out of the shift: exhausted rem is all-0 or all-1
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = out_valid;
  assign out_byte  = out_valid ? {~last, rem_q[6:0]} : 8'h00;
  assign out_last  = out_valid & last;
  assign byte_idx  = idx_q;

endmodule
